// File: rtl/if_icache_fetch.sv
// Instruction-fetch stage with a direct-mapped, one-word-per-line instruction
// cache. Hits stream one instruction per cycle to IF/ID; misses issue a
// single 32-bit read to the memory controller and refill the line.
module if_icache_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IDX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  localparam int unsigned LINES    = 1 << IDX_BITS;
  localparam int unsigned TAG_BITS = 32 - IDX_BITS - 2;

  // S_WAIT: miss outstanding, result wanted.
  // S_DRAIN: miss outstanding, pc already redirected; the transfer cannot be
  // aborted, so it is completed and the line written, but nothing is issued.
  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t              state_q;
  logic [31:0]         pc_q;
  logic                mem_req_q;
  logic [31:0]         mem_addr_q;
  logic [31:0]         pc_out_q;
  logic [31:0]         inst_q;
  logic                valid_q;

  logic [LINES-1:0]    line_vld_q;
  logic [TAG_BITS-1:0] tag_mem_q  [LINES];
  logic [31:0]         data_mem_q [LINES];

  logic [IDX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0] pc_tag;
  logic [IDX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0] fill_tag;
  logic                hit;
  logic [31:0]         hit_data;
  logic                fill_en;
  logic [31:0]         branch_pc;

  assign pc_idx    = pc_q[IDX_BITS+1:2];
  assign pc_tag    = pc_q[31:IDX_BITS+2];
  assign fill_idx  = mem_addr_q[IDX_BITS+1:2];
  assign fill_tag  = mem_addr_q[31:IDX_BITS+2];
  assign hit       = line_vld_q[pc_idx] && (tag_mem_q[pc_idx] == pc_tag);
  assign hit_data  = data_mem_q[pc_idx];
  assign branch_pc = branch_target_i & 32'hFFFF_FFFC;

  // A refill lands only while a request is outstanding; a stray ready in
  // S_FETCH (e.g. left over from a request abandoned by reset) is dropped.
  assign fill_en = !rst && mem_ready_i && (state_q != S_FETCH);

  // Line valid bits: cleared by reset, set by each completed refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_vld_q <= '0;
    end else if (fill_en) begin
      line_vld_q[fill_idx] <= 1'b1;
    end
  end

  // Line data and tag storage; no reset needed since the valid bits gate use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_mem_q[fill_idx] <= mem_data_i;
      tag_mem_q[fill_idx]  <= fill_tag;
    end
  end

  // Fetch controller: PC, miss handshake and registered IF/ID outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pc_out_q   <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (branch_i) begin
            pc_q    <= branch_pc;
            valid_q <= 1'b0;
          end else if (stall_i) begin
            // hold pc and every output
          end else if (hit) begin
            pc_out_q <= pc_q;
            inst_q   <= hit_data;
            valid_q  <= 1'b1;
            pc_q     <= pc_q + 32'd4;
          end else begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
            valid_q    <= 1'b0;
            state_q    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (branch_i) begin
            pc_q <= branch_pc;
          end
          // Refill completes even with a simultaneous redirect; only a
          // redirect without the data forces the drain path.
          if (mem_ready_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_FETCH;
          end else if (branch_i) begin
            state_q <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (branch_i) begin
            pc_q <= branch_pc;
          end
          if (mem_ready_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_FETCH;
          end
        end

        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign pc_o       = pc_out_q;
  assign inst_o     = inst_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_if_icache_fetch.sv
// Testbench for if_icache_fetch: directed scenarios followed by randomized
// branch/stall/reset traffic, checked by a scoreboard against an
// instruction-stream and cache-content reference model.
module tb_if_icache_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned IDX_BITS = 5;
  localparam int unsigned LINES    = 1 << IDX_BITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;

  // Memory responder and directed "stray" pulses share the ready/data lines.
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data = '0;
  logic        stray_ready = 1'b0;
  logic [31:0] stray_data = '0;
  assign mem_ready_i = resp_ready | stray_ready;
  assign mem_data_i  = stray_ready ? stray_data : resp_data;

  int errors = 0;
  int checks = 0;
  int ndeliv = 0;

  always #5 clk = ~clk;

  if_icache_fetch #(
    .RESET_PC(RESET_PC),
    .IDX_BITS(IDX_BITS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .mem_ready_i    (mem_ready_i),
    .mem_data_i     (mem_data_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .valid_o        (valid_o)
  );

  // Instruction memory contents: a fixed function of the word address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a << 14) ^ a ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds the next instruction address the fetch stream must deliver;
  // reset and each branch replace it, each delivery advances it by one word.
  logic [31:0] exp_q[$];
  logic        m_vld [LINES];
  logic [31:0] m_addr[LINES];
  bit          mon_en = 1'b0;
  logic        p_req, p_valid;
  logic [31:0] p_addr, p_pc, p_inst, mon_e;

  function automatic int lidx(input logic [31:0] a);
    return int'((a / 32'd4) % LINES);
  endfunction

  function automatic logic cached(input logic [31:0] a);
    return m_vld[lidx(a)] && (m_addr[lidx(a)] == a);
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      chk("rst_req", mem_req_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_pc", pc_o, 0);
      chk("rst_inst", inst_o, 0);
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      foreach (m_vld[i]) m_vld[i] = 1'b0;
      mon_en = 1'b1;
    end else if (mon_en) begin
      // memory handshake
      if (p_req) begin
        chk("wait_valid_low", valid_o, 0);
        if (mem_ready_i) begin
          chk("req_drop", mem_req_o, 0);
          m_vld[lidx(p_addr)]  = 1'b1;
          m_addr[lidx(p_addr)] = p_addr;
        end else begin
          chk("req_hold", mem_req_o, 1);
          chk("addr_hold", mem_addr_o, p_addr);
        end
      end else if (mem_req_o) begin
        chk("miss_addr", mem_addr_o, exp_q[0]);
        chk("miss_of_cached_line", cached(mem_addr_o), 0);
        chk("miss_valid_low", valid_o, 0);
      end
      // instruction outputs
      if (branch_i) begin
        chk("branch_valid_low", valid_o, 0);
        exp_q.delete();
        exp_q.push_back(branch_target_i & 32'hFFFF_FFFC);
      end else if (stall_i && p_valid) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_pc", pc_o, p_pc);
        chk("hold_inst", inst_o, p_inst);
      end else if (stall_i) begin
        chk("stall_valid_low", valid_o, 0);
      end else if (valid_o) begin
        mon_e = exp_q.pop_front();
        chk("deliver_pc", pc_o, mon_e);
        chk("deliver_inst", inst_o, memword(mon_e));
        chk("hit_without_line", cached(mon_e), 1);
        exp_q.push_back(mon_e + 32'd4);
        ndeliv++;
      end
    end
    p_req   = mem_req_o;
    p_valid = valid_o;
    p_addr  = mem_addr_o;
    p_pc    = pc_o;
    p_inst  = inst_o;
  end

  // ---------------- memory responder ----------------
  bit resp_en   = 1'b1;
  int lat_fixed = 3;
  int lat       = 0;
  int cnt       = 0;
  bit sent      = 1'b0;

  always @(negedge clk) begin
    resp_ready = 1'b0;
    if (!mem_req_o) begin
      cnt  = 0;
      sent = 1'b0;
      lat  = (lat_fixed < 0) ? int'($urandom_range(0, 4)) : lat_fixed;
    end else if (resp_en && !sent) begin
      if (cnt >= lat) begin
        resp_ready = 1'b1;
        resp_data  = memword(mem_addr_o);
        sent       = 1'b1;
      end else begin
        cnt++;
      end
    end
  end

  // Wait (bounded) for a delivery of the given pc.
  task automatic wait_valid(input logic [31:0] pc, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(valid_o && pc_o == pc) && n < 200);
    chk({name, "_valid"}, valid_o, 1);
    chk({name, "_pc"}, pc_o, pc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // cold start
    @(negedge clk);
    chk("cold_req", mem_req_o, 1);
    chk("cold_addr", mem_addr_o, 32'h0);
    repeat (3) @(negedge clk);
    chk("cold_req_wait", mem_req_o, 1);
    @(negedge clk);
    chk("cold_req_drop", mem_req_o, 0);
    chk("cold_valid_low", valid_o, 0);
    @(negedge clk);
    chk("cold_valid", valid_o, 1);
    chk("cold_pc", pc_o, 32'h0);
    chk("cold_inst", inst_o, 32'h0000_0013);
    lat_fixed = -1;

    // warm lines 0x0..0xC, then replay 0x0/0x4/0x8 as pure hits
    wait_valid(32'hC, "warm");
    branch_i = 1'b1;
    branch_target_i = 32'h0;
    @(negedge clk);
    branch_i = 1'b0;
    chk("br_valid_low", valid_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hit_valid", valid_o, 1);
      chk("hit_pc", pc_o, 32'(i * 4));
      chk("hit_noreq", mem_req_o, 0);
    end

    // stall for 3 cycles at pc_o=0x8
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", valid_o, 1);
      chk("stall_pc", pc_o, 32'h8);
      chk("stall_inst", inst_o, memword(32'h8));
    end
    stall_i = 1'b0;
    @(negedge clk);
    chk("resume_valid", valid_o, 1);
    chk("resume_pc", pc_o, 32'hC);

    // conflict miss: 0x80 evicts 0x0, refetch of 0x0 misses again
    branch_i = 1'b1;
    branch_target_i = 32'h80;
    @(negedge clk);
    branch_i = 1'b0;
    @(negedge clk);
    chk("conf_req", mem_req_o, 1);
    chk("conf_addr", mem_addr_o, 32'h80);
    wait_valid(32'h80, "conf");
    branch_i = 1'b1;
    branch_target_i = 32'h0;
    @(negedge clk);
    branch_i = 1'b0;
    @(negedge clk);
    chk("refetch_req", mem_req_o, 1);
    chk("refetch_addr", mem_addr_o, 32'h0);
    wait_valid(32'h0, "refetch");

    // redirect while a miss to 0x10 is outstanding
    branch_i = 1'b1;
    branch_target_i = 32'h10;
    resp_en = 1'b0;
    @(negedge clk);
    branch_i = 1'b0;
    @(negedge clk);
    chk("drain_req", mem_req_o, 1);
    chk("drain_addr", mem_addr_o, 32'h10);
    branch_i = 1'b1;
    branch_target_i = 32'h203;
    @(negedge clk);
    branch_i = 1'b0;
    chk("drain_hold_req", mem_req_o, 1);
    chk("drain_hold_addr", mem_addr_o, 32'h10);
    @(negedge clk);
    chk("drain_hold2_req", mem_req_o, 1);
    chk("drain_hold2_addr", mem_addr_o, 32'h10);
    stray_ready = 1'b1;
    stray_data  = memword(32'h10);
    @(negedge clk);
    stray_ready = 1'b0;
    chk("drain_drop", mem_req_o, 0);
    chk("drain_valid_low", valid_o, 0);
    @(negedge clk);
    chk("redir_req", mem_req_o, 1);
    chk("redir_addr", mem_addr_o, 32'h200);
    resp_en = 1'b1;
    wait_valid(32'h200, "redir");

    // reset during an outstanding miss, then a stray ready
    resp_en = 1'b0;
    @(negedge clk);
    chk("rw_req", mem_req_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rw_req_low", mem_req_o, 0);
    chk("rw_valid_low", valid_o, 0);
    rst = 1'b0;
    stray_ready = 1'b1;
    stray_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    stray_ready = 1'b0;
    chk("rw_newreq", mem_req_o, 1);
    chk("rw_newaddr", mem_addr_o, 32'h0);
    resp_en = 1'b1;
    wait_valid(32'h0, "rw");
    chk("rw_inst", inst_o, 32'h0000_0013);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 299) == 0);
      branch_i = !rst && ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0)
        branch_target_i = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      else
        branch_target_i = 32'($urandom_range(0, 1023));
      stall_i  = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    rst      = 1'b0;
    branch_i = 1'b0;
    stall_i  = 1'b0;
    repeat (10) @(negedge clk);
    chk("enough_deliveries", 32'(ndeliv > 300), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_icache_fetch.md
Name: if_icache_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the memory controller.
- Holds the PC and a direct-mapped, one-word-per-line instruction cache.
- On a hit it supplies one instruction per cycle to the IF/ID register; on a miss it requests a 32-bit read from the memory controller (ife/pc → ifready/ifdata handshake) and refills the line.
- Handles branch redirects and pipeline stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- IDX_BITS, 5, cache index width; line count = 2**IDX_BITS.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  hold request from stall control; freezes the PC and the outputs.
- branch_i  in  1  one-cycle redirect pulse.
- branch_target_i  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- mem_ready_i  in  1  one-cycle pulse from the memory controller: instruction word valid.
- mem_data_i  in  32  instruction word; valid only while mem_ready_i=1.
- mem_req_o  out  1  fetch request level to the memory controller.
- mem_addr_o  out  32  fetch address; stable while mem_req_o=1.
- pc_o  out  32  PC of inst_o.
- inst_o  out  32  instruction to IF/ID.
- valid_o  out  1  pc_o/inst_o hold a real instruction.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - pc := RESET_PC; state := S_FETCH.
  - All line valid bits := 0.
  - Outputs: mem_req_o=0, mem_addr_o=0, pc_o=0, inst_o=0, valid_o=0.
  - Reset mid-miss abandons the request; a later mem_ready_i is ignored unless in S_WAIT/S_DRAIN.
- Address split: index = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]. Hit = valid[index] && tag match.
- States:
  - S_FETCH, S_WAIT (miss outstanding), S_DRAIN (miss outstanding, result no longer wanted after a redirect).
- S_FETCH, evaluated in this priority order:
  - branch_i=1: pc := target & ~3; valid_o := 0; stay in S_FETCH.
  - Else stall_i=1: pc and all outputs hold.
  - Else hit: pc_o := pc; inst_o := line data; valid_o := 1; pc := pc+4 (wraps modulo 2^32). Throughput is 1 instruction per cycle.
  - Else miss: mem_req_o := 1; mem_addr_o := pc; valid_o := 0; go to S_WAIT.
- S_WAIT:
  - mem_req_o stays 1 and mem_addr_o is held.
  - On mem_ready_i: write the line (data, tag, valid=1); mem_req_o := 0; go to S_FETCH. The next cycle hits, so miss-to-valid_o latency is 2 cycles after mem_ready_i.
  - branch_i=1 without mem_ready_i: pc := target; go to S_DRAIN.
  - branch_i and mem_ready_i together: the line is still written; pc := target; go to S_FETCH.
  - stall_i does not block the refill; outputs hold, valid_o stays 0.
- S_DRAIN:
  - mem_req_o stays 1 until mem_ready_i. The memory controller cannot abort a transfer, so the request must complete.
  - On mem_ready_i: the line is written (the address is genuine); mem_req_o := 0; go to S_FETCH with the redirected pc.
  - A further branch_i in S_DRAIN only updates pc.
- valid_o is 0 in every cycle not produced by a hit in S_FETCH, except while held by stall_i.
- mem_req_o deasserts in the cycle after the mem_ready_i edge. A new request is never raised in the same cycle mem_ready_i is seen.
- No writes to instruction memory; self-modifying code is unsupported.

Test Plan:
- Reset, then cold start at RESET_PC=0:
  - Required: mem_req_o=1 with mem_addr_o=0 one cycle after rst falls.
  - Drive mem_ready_i with data 32'h00000013 four cycles later → mem_req_o=0 the next cycle; then valid_o=1, pc_o=0, inst_o=32'h00000013; pc advances to 4.
- Hit stream: preload lines at 0x0, 0x4, 0x8 → three consecutive cycles of valid_o=1 with pc_o=0,4,8 and no mem_req_o.
- Conflict miss (IDX_BITS=5): fetch 0x000, then branch to 0x080 (same index, different tag) → miss raised with mem_addr_o=0x80; the line is replaced; refetch of 0x000 misses again.
- Branch during S_WAIT for 0x10, branch_target_i=0x203 → mem_req_o stays 1 at 0x10 until mem_ready_i; the next request or hit is at 0x200; the 0x10 data never appears on valid_o.
- stall_i held 3 cycles during a hit stream at pc_o=0x8 → pc_o/inst_o/valid_o unchanged for those 3 cycles; resumes with pc_o=0xC.
- rst asserted while in S_WAIT → the next cycle mem_req_o=0 and valid_o=0; a stray mem_ready_i is ignored; all lines read as miss.
